fifo_rd_stream: RTL

- Read-side companion for the team's synchronous FIFO. It drives that FIFO's rd_req/empty/rd_data port and presents the words as a valid/ready stream to a downstream consumer.
- It absorbs the FIFO's read latency, either 0 cycles (combinational LUTRAM/register read) or 1 cycle (BRAM/URAM, or the extra output stage). It does this with a small credit-tracked skid buffer.
- It never issues a read to an empty FIFO and never drops a word except on an explicit flush.

---
 rtl/fifo_rd_stream.sv | 77 +++++++
 1 files changed

// File: rtl/fifo_rd_stream.sv
// fifo_rd_stream: credit-tracked skid buffer turning a 0/1-latency FIFO read port into a valid/ready stream
module fifo_rd_stream #(
    parameter int DATA_W     = 64,
    parameter int RD_LATENCY = 1,
    parameter int SKID_DEPTH = 3
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                fifo_empty_i,
    output logic                                fifo_rd_req_o,
    input  logic [DATA_W-1:0]                   fifo_rd_data_i,
    output logic                                m_valid_o,
    input  logic                                m_ready_i,
    output logic [DATA_W-1:0]                   m_data_o,
    input  logic                                flush_i,
    output logic [$clog2(SKID_DEPTH+1)-1:0]     occupancy_o
);
    localparam int OCC_W = $clog2(SKID_DEPTH + 1);
    localparam int PTR_W = SKID_DEPTH > 1 ? $clog2(SKID_DEPTH) : 1;

    if (RD_LATENCY != 0 && RD_LATENCY != 1) begin : g_bad_latency
        $error("fifo_rd_stream: RD_LATENCY must be 0 or 1");
    end
    if (SKID_DEPTH < RD_LATENCY + 1) begin : g_bad_depth
        $error("fifo_rd_stream: SKID_DEPTH must be at least RD_LATENCY+1");
    end

    logic                run_q, run_d;
    logic [OCC_W-1:0]    occ_q, occ_d;
    logic                inflight_q, inflight_d;
    logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [DATA_W-1:0]   mem_q [SKID_DEPTH];
    logic [DATA_W-1:0]   mem_d [SKID_DEPTH];
    logic [OCC_W:0]      credit;
    logic                capture, pop;

    function automatic logic [PTR_W-1:0] wrap_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(SKID_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign m_valid_o   = occ_q != '0;
    assign m_data_o    = mem_q[rd_ptr_q];
    assign occupancy_o = occ_q;

    // Credit uses registered state only, so m_ready_i never reaches the read request
    always_comb begin
        credit        = {1'b0, occ_q} + (OCC_W + 1)'(inflight_q);
        fifo_rd_req_o = run_q & ~flush_i & ~fifo_empty_i & (credit < (OCC_W + 1)'(SKID_DEPTH));
        capture       = (RD_LATENCY == 0 ? fifo_rd_req_o : inflight_q) & ~flush_i;
        pop           = m_valid_o & m_ready_i;
        run_d         = 1'b1;
        inflight_d    = (RD_LATENCY == 1) && fifo_rd_req_o;
        mem_d         = mem_q;
        if (capture) mem_d[wr_ptr_q] = fifo_rd_data_i;
        wr_ptr_d      = flush_i ? '0 : capture ? wrap_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d      = flush_i ? '0 : pop ? wrap_inc(rd_ptr_q) : rd_ptr_q;
        occ_d         = flush_i ? '0 : occ_q + OCC_W'(capture) - OCC_W'(pop);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_q      <= 1'b0;
            occ_q      <= '0;
            inflight_q <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            mem_q      <= '{default: '0};
        end else begin
            run_q      <= run_d;
            occ_q      <= occ_d;
            inflight_q <= inflight_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            mem_q      <= mem_d;
        end
    end
endmodule
